tmds_decoder: RTL and testbench

TMDS_DECODER -- requirements
Module: tmds_decoder

---
 rtl/tmds_decoder.sv | 161 ++++++++++++++++
 tb/tb_tmds_decoder.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_decoder.sv
// TMDS symbol decoder with control-token word alignment.
// Two-stage pipeline (input register, decode register) plus a SEARCH/SLIP_HOLD/LOCKED aligner.
module tmds_decoder #(
  parameter int CTRL_RUN   = 8,
  parameter int SEARCH_LEN = 2048,
  parameter int SLIP_WAIT  = 16
) (
  input  logic       i_pix_clk,
  input  logic       i_rst,
  input  logic [9:0] i_tmds,
  output logic [7:0] o_data,
  output logic [1:0] o_ctrl,
  output logic       o_de,
  output logic       o_aligned,
  output logic       o_bitslip
);

  localparam int TW = (SEARCH_LEN > 1) ? $clog2(SEARCH_LEN) : 1;
  localparam int RW = $clog2(CTRL_RUN + 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(SEARCH_LEN - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(SLIP_WAIT - 1);
  localparam logic [RW-1:0] RUN_FULL  = RW'(CTRL_RUN);

  typedef enum logic [1:0] {
    SEARCH,
    SLIP_HOLD,
    LOCKED
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [9:0]      tmds_q;
  logic [RW-1:0]   run_cnt;
  logic [RW-1:0]   run_next;
  logic [TW-1:0]   timer;
  logic [TW-1:0]   timer_next;
  logic [TW-1:0]   timer_inc;
  logic            is_ctrl;
  logic [1:0]      tok;
  logic [7:0]      d;
  logic [7:0]      data_dec;
  logic            run_done;
  logic            slip_next;
  logic            lock_next;
  logic [1:0]      last_ctrl;

  always_comb begin
    is_ctrl = 1'b1;
    tok     = 2'b00;
    case (tmds_q)
      10'h354: tok = 2'b00;
      10'h0AB: tok = 2'b01;
      10'h154: tok = 2'b10;
      10'h2AB: tok = 2'b11;
      default: is_ctrl = 1'b0;
    endcase
  end

  // Undo the optional inversion, then the XOR/XNOR transition chain.
  always_comb begin
    d           = tmds_q[9] ? ~tmds_q[7:0] : tmds_q[7:0];
    data_dec    = '0;
    data_dec[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      data_dec[i] = tmds_q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
  end

  always_comb begin
    run_next = '0;
    if (state != SLIP_HOLD && is_ctrl) begin
      run_next = (run_cnt == RUN_FULL) ? run_cnt : run_cnt + 1'b1;
    end
    run_done  = (state != SLIP_HOLD) && is_ctrl && (run_next == RUN_FULL);
    timer_inc = (timer == TIMER_MAX) ? timer : timer + 1'b1;
  end

  // Lock takes priority over a bit-slip when both fall in the same cycle.
  always_comb begin
    state_next = state;
    timer_next = timer_inc;
    slip_next  = 1'b0;
    unique case (state)
      SEARCH: begin
        if (run_done) begin
          state_next = LOCKED;
          timer_next = '0;
        end else if (timer == TIMER_MAX) begin
          state_next = SLIP_HOLD;
          timer_next = '0;
          slip_next  = 1'b1;
        end
      end
      SLIP_HOLD: begin
        if (timer == HOLD_LAST) begin
          state_next = SEARCH;
          timer_next = '0;
        end
      end
      LOCKED: begin
        if (run_done) begin
          timer_next = '0;
        end else if (timer == TIMER_MAX) begin
          state_next = SEARCH;
          timer_next = '0;
        end
      end
      default: begin
        state_next = SEARCH;
        timer_next = '0;
      end
    endcase
    lock_next = (state_next == LOCKED);
  end

  always_ff @(posedge i_pix_clk) begin
    if (i_rst) begin
      state   <= SEARCH;
      tmds_q  <= '0;
      run_cnt <= '0;
      timer   <= '0;
    end else begin
      state   <= state_next;
      tmds_q  <= i_tmds;
      run_cnt <= run_next;
      timer   <= timer_next;
    end
  end

  // Outputs are gated by the next state so o_aligned and the first locked symbol line up.
  always_ff @(posedge i_pix_clk) begin
    if (i_rst) begin
      last_ctrl <= 2'b00;
      o_data    <= 8'h00;
      o_ctrl    <= 2'b00;
      o_de      <= 1'b0;
      o_aligned <= 1'b0;
      o_bitslip <= 1'b0;
    end else begin
      if (is_ctrl) begin
        last_ctrl <= tok;
      end
      o_aligned <= lock_next;
      o_bitslip <= slip_next;
      if (!lock_next) begin
        o_data <= 8'h00;
        o_ctrl <= 2'b00;
        o_de   <= 1'b0;
      end else if (is_ctrl) begin
        o_data <= 8'h00;
        o_ctrl <= tok;
        o_de   <= 1'b0;
      end else begin
        o_data <= data_dec;
        o_ctrl <= last_ctrl;
        o_de   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tmds_decoder.sv
// Self-checking bench for tmds_decoder: random and directed symbol streams
// compared cycle by cycle against a behavioural model of the aligner and decoder.
module tb_tmds_decoder;

  localparam int CTRL_RUN   = 8;
  localparam int SEARCH_LEN = 2048;
  localparam int SLIP_WAIT  = 16;
  localparam logic [9:0] TOKENS [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] tmds;
  logic [7:0] o_data;
  logic [1:0] o_ctrl;
  logic       o_de;
  logic       o_aligned;
  logic       o_bitslip;
  logic [12:0] dut_vec;

  int checks = 0;
  int errors = 0;

  logic [9:0] pipe_q;
  int         run;
  int         age;
  int         hold_left;
  bit         locked;
  logic [1:0] last_tok;
  logic [7:0] m_data;
  logic [1:0] m_ctrl;
  logic       m_de;
  logic       m_aligned;
  logic       m_slip;
  logic [12:0] m_vec;

  always #5 clk = ~clk;

  tmds_decoder #(
    .CTRL_RUN  (CTRL_RUN),
    .SEARCH_LEN(SEARCH_LEN),
    .SLIP_WAIT (SLIP_WAIT)
  ) dut (
    .i_pix_clk(clk),
    .i_rst    (rst),
    .i_tmds   (tmds),
    .o_data   (o_data),
    .o_ctrl   (o_ctrl),
    .o_de     (o_de),
    .o_aligned(o_aligned),
    .o_bitslip(o_bitslip)
  );

  assign dut_vec = {o_data, o_ctrl, o_de, o_aligned, o_bitslip};
  assign m_vec   = {m_data, m_ctrl, m_de, m_aligned, m_slip};

  function automatic int tok_index(input logic [9:0] q);
    for (int k = 0; k < 4; k++) begin
      if (q == TOKENS[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [7:0] decode(input logic [9:0] q);
    logic [7:0] dd;
    logic [7:0] x;
    dd = q[9] ? ~q[7:0] : q[7:0];
    x  = dd ^ {dd[6:0], 1'b0};
    if (!q[8]) x = ~x;
    return {x[7:1], dd[0]};
  endfunction

  function automatic logic [9:0] rand_data();
    logic [9:0] v;
    v = 10'($urandom_range(0, 1023));
    if (tok_index(v) >= 0) v = v ^ 10'h001;
    return v;
  endfunction

  task automatic model_reset();
    run = 0; age = 0; hold_left = 0; locked = 0; last_tok = 2'b00;
    m_data = 8'h00; m_ctrl = 2'b00; m_de = 1'b0; m_aligned = 1'b0; m_slip = 1'b0;
  endtask

  task automatic model_step(input logic [9:0] q);
    int  t;
    bit  done;
    t      = tok_index(q);
    m_slip = 1'b0;
    if (hold_left > 0) begin
      run = 0;
      hold_left--;
      if (hold_left == 0) age = 0;
    end else begin
      run  = (t >= 0) ? ((run < CTRL_RUN) ? run + 1 : run) : 0;
      done = (t >= 0) && (run == CTRL_RUN);
      if (!locked) begin
        if (done) begin
          locked = 1; age = 0;
        end else if (age == SEARCH_LEN - 1) begin
          m_slip = 1'b1; hold_left = SLIP_WAIT; age = 0;
        end else begin
          age++;
        end
      end else begin
        if (done) age = 0;
        else if (age == SEARCH_LEN - 1) begin
          locked = 0; age = 0;
        end else age++;
      end
    end
    m_aligned = locked;
    if (!locked) begin
      m_data = 8'h00; m_ctrl = 2'b00; m_de = 1'b0;
    end else if (t >= 0) begin
      m_data = 8'h00; m_ctrl = 2'(t); m_de = 1'b0;
    end else begin
      m_data = decode(q); m_ctrl = last_tok; m_de = 1'b1;
    end
    if (t >= 0) last_tok = 2'(t);
  endtask

  task automatic tick(input logic [9:0] sym, input logic r);
    tmds = sym;
    rst  = r;
    @(posedge clk);
    if (r) model_reset();
    else model_step(pipe_q);
    pipe_q = r ? 10'h000 : sym;
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(rand_data(), 1'b1);
      checks++;
      if (dut_vec !== 13'h0000) begin
        errors++;
        $display("[TB] FAIL reset_outputs cyc=%0d got=%h want=0000", i, dut_vec);
      end
    end
  endtask

  task automatic test_lock();
    for (int i = 1; i <= 8; i++) begin
      tick(10'h354, 1'b0);
      checks++;
      if (dut_vec !== m_vec) begin
        errors++;
        $display("[TB] FAIL lock_model cyc=%0d got=%h want=%h", i, dut_vec, m_vec);
      end
    end
    checks++;
    if (o_aligned !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lock_early got=%b want=0", o_aligned);
    end
    tick(10'h100, 1'b0);
    checks++;
    if ({o_aligned, o_ctrl, o_de} !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL lock_edge got aligned/ctrl/de=%b%b%b want=1000", o_aligned, o_ctrl, o_de);
    end
  endtask

  task automatic test_data();
    tick(10'h2FF, 1'b0);
    checks++;
    if ({o_de, o_data, o_ctrl} !== {1'b1, 8'h00, 2'b00}) begin
      errors++;
      $display("[TB] FAIL data_0x100 got de=%b data=%h ctrl=%b want de=1 data=00 ctrl=00", o_de, o_data, o_ctrl);
    end
    tick(10'h354, 1'b0);
    checks++;
    if ({o_de, o_data, o_ctrl} !== {1'b1, 8'hFE, 2'b00}) begin
      errors++;
      $display("[TB] FAIL data_0x2FF got de=%b data=%h ctrl=%b want de=1 data=FE ctrl=00", o_de, o_data, o_ctrl);
    end
    tick(10'h354, 1'b0);
    checks++;
    if (dut_vec !== m_vec) begin
      errors++;
      $display("[TB] FAIL data_back_to_ctrl got=%h want=%h", dut_vec, m_vec);
    end
  endtask

  task automatic test_random_traffic();
    int n = 0;
    while (n < 400) begin
      int         len;
      logic [9:0] t;
      bit         ctrl_seg;
      ctrl_seg = ($urandom_range(0, 2) == 0);
      len      = ctrl_seg ? $urandom_range(1, 10) : $urandom_range(1, 20);
      t        = TOKENS[$urandom_range(0, 3)];
      for (int i = 0; i < len; i++) begin
        tick(ctrl_seg ? t : rand_data(), 1'b0);
        n++;
        checks++;
        if (dut_vec !== m_vec) begin
          errors++;
          $display("[TB] FAIL random_traffic cyc=%0d got=%h want=%h", n, dut_vec, m_vec);
        end
      end
    end
  endtask

  task automatic test_false_run();
    tick(10'h000, 1'b1);
    for (int i = 1; i <= 17; i++) begin
      tick((i == 8) ? 10'h100 : 10'h0AB, 1'b0);
      checks++;
      if (dut_vec !== m_vec) begin
        errors++;
        $display("[TB] FAIL false_run_model cyc=%0d got=%h want=%h", i, dut_vec, m_vec);
      end
      if (i == 16) begin
        checks++;
        if (o_aligned !== 1'b0) begin
          errors++;
          $display("[TB] FAIL false_run_early got=%b want=0", o_aligned);
        end
      end
    end
    checks++;
    if ({o_aligned, o_ctrl} !== 3'b101) begin
      errors++;
      $display("[TB] FAIL false_run_lock got aligned/ctrl=%b%b want=101", o_aligned, o_ctrl);
    end
  endtask

  task automatic test_bitslip();
    int pulses = 0;
    tick(10'h000, 1'b1);
    for (int n = 1; n <= 4112; n++) begin
      tick(10'h3FF, 1'b0);
      if (o_bitslip === 1'b1) pulses++;
      checks++;
      if (dut_vec !== m_vec) begin
        errors++;
        $display("[TB] FAIL bitslip_model cyc=%0d got=%h want=%h", n, dut_vec, m_vec);
      end
      if (n == 2048 || n == 4112) begin
        checks++;
        if (o_bitslip !== 1'b1) begin
          errors++;
          $display("[TB] FAIL bitslip_pulse cyc=%0d got=%b want=1", n, o_bitslip);
        end
      end
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("[TB] FAIL bitslip_count got=%0d want=2", pulses);
    end
    tick(10'h3FF, 1'b1);
    checks++;
    if (dut_vec !== 13'h0000) begin
      errors++;
      $display("[TB] FAIL bitslip_reset got=%h want=0000", dut_vec);
    end
    for (int n = 0; n < 20; n++) begin
      tick(10'h3FF, 1'b0);
      checks++;
      if (dut_vec !== m_vec) begin
        errors++;
        $display("[TB] FAIL bitslip_after_reset cyc=%0d got=%h want=%h", n, dut_vec, m_vec);
      end
    end
  endtask

  task automatic test_lock_loss();
    int pulses = 0;
    tick(10'h000, 1'b1);
    for (int i = 0; i < 8; i++) tick(10'h154, 1'b0);
    for (int n = 1; n <= 2060; n++) begin
      tick(rand_data(), 1'b0);
      if (o_bitslip === 1'b1) pulses++;
      checks++;
      if (dut_vec !== m_vec) begin
        errors++;
        $display("[TB] FAIL lock_loss_model cyc=%0d got=%h want=%h", n, dut_vec, m_vec);
      end
      if (n == 2048 || n == 2049) begin
        checks++;
        if (o_aligned !== (n == 2048)) begin
          errors++;
          $display("[TB] FAIL lock_loss_edge cyc=%0d got=%b want=%b", n, o_aligned, (n == 2048));
        end
      end
    end
    checks++;
    if (pulses != 0 || o_de !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lock_loss_quiet got slips=%0d de=%b want slips=0 de=0", pulses, o_de);
    end
  endtask

  task automatic test_reset_mid();
    tick(10'h000, 1'b1);
    for (int i = 0; i < 9; i++) tick(10'h2AB, 1'b0);
    for (int i = 0; i < 5; i++) tick(rand_data(), 1'b0);
    checks++;
    if (o_aligned !== 1'b1 || o_de !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_mid_precond got aligned=%b de=%b want 1 1", o_aligned, o_de);
    end
    tick(rand_data(), 1'b1);
    checks++;
    if (dut_vec !== 13'h0000) begin
      errors++;
      $display("[TB] FAIL reset_mid_outputs got=%h want=0000", dut_vec);
    end
    for (int i = 0; i < 20; i++) begin
      tick((i < 7 || i >= 9) ? 10'h2AB : rand_data(), 1'b0);
      checks++;
      if (dut_vec !== m_vec) begin
        errors++;
        $display("[TB] FAIL reset_mid_relock cyc=%0d got=%h want=%h", i, dut_vec, m_vec);
      end
    end
    checks++;
    if ({o_aligned, o_ctrl} !== 3'b111) begin
      errors++;
      $display("[TB] FAIL reset_mid_final got aligned/ctrl=%b%b want=111", o_aligned, o_ctrl);
    end
  endtask

  initial begin
    pipe_q = 10'h000;
    model_reset();
    test_reset();
    test_lock();
    test_data();
    test_random_traffic();
    test_false_run();
    test_bitslip();
    test_lock_loss();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
